m_capture: RTL
==============

# m_capture

Trigger/capture controller sitting directly downstream of the transition finder. Consumes the finder's delayed sample and its positive/negative transition flags. Records samples into an internal circular buffer with programmable pre-trigger depth, and stops after the post-trigger region is filled. Presents the frozen record through a synchronous read port, ordered oldest-first.

## Interface
- WIDTH, 8, sample width; matches the finder's sample width.
- ADDR_W, 4, buffer address width; DEPTH = 2^ADDR_W samples.
- AUTO_CYCLES, 1000, ARMED cycles before an auto-trigger fires; used only with M_CAPTURE_AUTO_EN.

- clk  in  1  sample clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sample  in  WIDTH  sample aligned with positive/negative (the finder's out).
- positive  in  1  rising-transition flag from the finder.
- negative  in  1  falling-transition flag from the finder.
- trig_sel  in  2  trigger source: 00 positive, 01 negative, 10 either, 11 immediate.
- pre_len  in  ADDR_W  number of pre-trigger samples; latched at start.
- start  in  1  one-cycle pulse that begins a capture.
- abort  in  1  one-cycle pulse that cancels the capture.
- busy  out  1  high in PRE, ARMED and POST.
- done  out  1  level; high in DONE.
- trig_pos  out  ADDR_W  physical buffer address of the trigger sample.
- auto_trig  out  1  the last capture was auto-triggered.
- rd_addr  in  ADDR_W  logical read index; 0 = oldest sample of the record.
- rd_data  out  WIDTH  registered read data.

## Operation
- States: IDLE, PRE, ARMED, POST, DONE.
- Reset: IDLE; busy, done, trig_pos, auto_trig and rd_data are all 0. Buffer contents are not reset.
- start in IDLE or DONE:
  - Latches pre_len; clears done, auto_trig and the write address.
  - Goes to PRE, or straight to ARMED if pre_len = 0.
  - start in any other state is ignored.
- Writes: in PRE, ARMED and POST, every cycle writes sample to mem[wr_addr], then wr_addr increments modulo DEPTH. No writes occur in IDLE or DONE.
- PRE:
  - Counts writes and moves to ARMED once pre_len samples have been written.
  - Trigger flags are ignored in PRE.
- ARMED:
  - Keeps writing, wrapping freely.
  - On the first cycle the selected trigger is true, trig_pos is set to the address written in that cycle (the trigger sample), then the block enters POST.
  - trig_sel = 11 triggers on the first ARMED cycle.
- POST:
  - Writes exactly DEPTH-1-pre_len further samples, then enters DONE.
  - If pre_len = DEPTH-1, goes from ARMED directly to DONE on the trigger cycle.
- Record layout: physical address = (trig_pos - pre_len + rd_addr) mod DEPTH. rd_addr = pre_len returns the trigger sample.
- abort: in any state, goes to IDLE and clears busy and done. abort beats start in the same cycle.
- The read port works in every state. Its data is meaningful only in DONE.

## Timing
- busy rises the cycle after start; the first write happens in that same first busy cycle.
- Trigger-cycle sample is written in the cycle it is presented; flags and sample are never re-aligned internally.
- done and the busy fall occur on the cycle after the last POST write.
- rd_data = mem[mapped(rd_addr)] one cycle after rd_addr is presented.
- trig_pos is stable from the POST entry cycle until the next start.

## Configuration
- M_CAPTURE_AUTO_EN defined:
  - A 32-bit counter runs only in ARMED and clears on entry to ARMED.
  - When it reaches AUTO_CYCLES with no trigger, a forced trigger occurs exactly as a real one would, and auto_trig is set to 1 until the next start.
- M_CAPTURE_AUTO_EN undefined: ARMED waits indefinitely, auto_trig is tied 0, and no counter is built.

## Test plan
- Reset:
  - Stimulus: assert rst_n low mid-POST.
  - Required: immediately busy = 0, done = 0, trig_pos = 0, rd_data = 0; state IDLE.
- Basic capture (ADDR_W = 4, ramp sample = write index, pre_len = 4, trig_sel = 00):
  - Stimulus: positive high at write 9.
  - Required: trig_pos = 9; writes continue through index 20; done rises the next cycle; rd_addr 0..15 returns 5..20; rd_addr 4 returns 9.
- Trigger masked in PRE:
  - Stimulus: pre_len = 4, positive at write 2 only.
  - Required: stays ARMED, busy = 1 for 50 cycles.
  - Stimulus: then negative with trig_sel = 10.
  - Required: triggers.
- Full pre-trigger:
  - Stimulus: pre_len = 15, trig_sel = 11.
  - Required: trig_pos = 15; done on the cycle after the trigger write; rd_addr 15 returns the trigger sample.
- Abort:
  - Stimulus: abort during POST.
  - Required: IDLE, busy = 0, done = 0.
  - Stimulus: start and abort in the same cycle.
  - Required: remains IDLE.
  - Stimulus: start during ARMED.
  - Required: ignored; trig_pos is unchanged after the capture completes.
- Auto-trigger:
  - Stimulus: with M_CAPTURE_AUTO_EN, AUTO_CYCLES = 20, no flags.
  - Required: triggers on ARMED cycle 20; auto_trig = 1; done follows.
  - Stimulus: same, without the macro.
  - Required: still ARMED after 100 cycles; auto_trig = 0.

Source files
------------

// File: rtl/m_capture.sv
// Trigger/capture controller: circular sample buffer with pre-trigger depth, frozen record read oldest-first.
// Optional auto-trigger after AUTO_CYCLES armed cycles is built only when M_CAPTURE_AUTO_EN is defined.
module m_capture #(
  parameter int WIDTH       = 8,
  parameter int ADDR_W      = 4,
  parameter int AUTO_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  sample,
  input  logic              positive,
  input  logic              negative,
  input  logic [1:0]        trig_sel,
  input  logic [ADDR_W-1:0] pre_len,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_pos,
  output logic              auto_trig,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] pre_len_q, pre_len_d;
  logic [ADDR_W-1:0] trig_pos_q, trig_pos_d;
  logic              auto_trig_q, auto_trig_d;
  logic [WIDTH-1:0]  rd_data_q;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              wr_en;
  logic              trig_hit;
  logic              auto_fire;
  logic [ADDR_W-1:0] post_last;
  logic [ADDR_W-1:0] rd_phys;

  always_comb begin
    unique case (trig_sel)
      2'b00:   trig_hit = positive;
      2'b01:   trig_hit = negative;
      2'b10:   trig_hit = positive | negative;
      default: trig_hit = 1'b1;
    endcase
  end

`ifdef M_CAPTURE_AUTO_EN
  localparam logic [31:0] AUTO_LAST = 32'(AUTO_CYCLES - 1);
  logic [31:0] auto_cnt_q, auto_cnt_d;

  // Counter is zero whenever we are outside ARMED, so it restarts on every ARMED entry.
  assign auto_fire  = (state_q == S_ARMED) && (auto_cnt_q == AUTO_LAST);
  assign auto_cnt_d = (state_q == S_ARMED) ? auto_cnt_q + 32'd1 : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) auto_cnt_q <= 32'd0;
    else        auto_cnt_q <= auto_cnt_d;
  end
`else
  assign auto_fire = 1'b0;
`endif

  assign wr_en     = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
  assign post_last = LAST_ADDR - ONE - pre_len_q;

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_en ? wr_addr_q + ONE : wr_addr_q;
    cnt_d       = cnt_q;
    pre_len_d   = pre_len_q;
    trig_pos_d  = trig_pos_q;
    auto_trig_d = auto_trig_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            pre_len_d   = pre_len;
            wr_addr_d   = '0;
            cnt_d       = '0;
            auto_trig_d = 1'b0;
            state_d     = (pre_len == '0) ? S_ARMED : S_PRE;
          end
        end
        S_PRE: begin
          cnt_d = cnt_q + ONE;
          if (cnt_q == pre_len_q - ONE) begin
            cnt_d   = '0;
            state_d = S_ARMED;
          end
        end
        S_ARMED: begin
          if (trig_hit || auto_fire) begin
            trig_pos_d = wr_addr_q;
            cnt_d      = '0;
            if (!trig_hit) auto_trig_d = 1'b1;
            // With a full pre-trigger region the trigger sample is the last one.
            state_d = (pre_len_q == LAST_ADDR) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          cnt_d = cnt_q + ONE;
          if (cnt_q == post_last) state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_addr_q   <= '0;
      cnt_q       <= '0;
      pre_len_q   <= '0;
      trig_pos_q  <= '0;
      auto_trig_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      cnt_q       <= cnt_d;
      pre_len_q   <= pre_len_d;
      trig_pos_q  <= trig_pos_d;
      auto_trig_q <= auto_trig_d;
      rd_data_q   <= mem[rd_phys];
    end
  end

  // Buffer contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr_q] <= sample;
  end

  assign rd_phys   = trig_pos_q - pre_len_q + rd_addr;
  assign busy      = wr_en;
  assign done      = (state_q == S_DONE);
  assign trig_pos  = trig_pos_q;
  assign auto_trig = auto_trig_q;
  assign rd_data   = rd_data_q;
  assign dbg_state = state_q;

endmodule
